opb_register_bank: RTL and testbench

OPB_REGISTER_BANK -- requirements
Module: opb_register_bank

---
 rtl/opb_register_bank_pkg.sv | 27 ++
 rtl/opb_register_bank_if.sv | 33 +++
 rtl/opb_register_bank_slot.sv | 65 ++++++
 rtl/opb_register_bank.sv | 152 +++++++++++++++
 tb/tb_opb_register_bank.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/opb_register_bank_pkg.sv
// -----------------------------------------------------------------------------
// opb_register_bank_pkg
// Shared definitions for the OPB register bank: word and byte-lane sizes, the
// transfer FSM state encoding and the byte-address to register-index mapping.
// -----------------------------------------------------------------------------
package opb_register_bank_pkg;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned BYTE_LANES = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_HOLD = 2'd2
   } opb_state_e;

   // Registers are word-aligned, so the low two offset bits are dropped.
   function automatic logic [WORD_W-1:0] addr_to_index(
      input logic [WORD_W-1:0] addr,
      input logic [WORD_W-1:0] base
   );
      logic [WORD_W-1:0] offset_s;
      offset_s = addr - base;
      return {2'b00, offset_s[WORD_W-1:2]};
   endfunction

endpackage

// File: rtl/opb_register_bank_if.sv
// -----------------------------------------------------------------------------
// opb_register_bank_if
// OPB slave-side bus bundle. Vectors keep the IBM big-endian numbering: bit 0
// is the most significant bit.
//   slave  : OPB_* inputs, Sl_* outputs (the register bank)
//   master : the opposite direction (bus driver / bench)
// -----------------------------------------------------------------------------
interface opb_register_bank_if;

   logic [0:31] OPB_ABus;
   logic [0:3]  OPB_BE;
   logic [0:31] OPB_DBus;
   logic        OPB_RNW;
   logic        OPB_select;
   logic        OPB_seqAddr;

   logic [0:31] Sl_DBus;
   logic        Sl_xferAck;
   logic        Sl_errAck;
   logic        Sl_retry;
   logic        Sl_toutSup;

   modport slave (
      input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
   );

   modport master (
      output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
   );

endinterface

// File: rtl/opb_register_bank_slot.sv
// -----------------------------------------------------------------------------
// opb_reg_slot
// One 32-bit user register with byte-lane write, optional autoclear (pulse
// register) and a one-cycle write strobe aligned with the new value.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   wr_en      : one-cycle write request for this register
//   wr_data    : write data, user bit order (bit 31 = MSB)
//   wr_be      : byte enables, wr_be[j] enables bits [8j+7:8j]
//   data_out   : current register value
//   wr_strobe  : high in the first cycle the written value is visible
// -----------------------------------------------------------------------------
module opb_reg_slot
   import opb_register_bank_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_VALUE = 32'h0000_0000,
   parameter bit                AUTOCLEAR   = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [WORD_W-1:0]     wr_data,
   input  logic [BYTE_LANES-1:0] wr_be,
   output logic [WORD_W-1:0]     data_out,
   output logic                  wr_strobe
);

   logic [WORD_W-1:0] data_r;
   logic [WORD_W-1:0] merged_s;
   logic              strobe_r;

   // Byte-lane merge of the write data over the current contents.
   always_comb begin
      merged_s = data_r;
      for (int j = 0; j < BYTE_LANES; j++) begin
         if (wr_be[j]) begin
            merged_s[8*j +: 8] = wr_data[8*j +: 8];
         end else begin
            merged_s[8*j +: 8] = data_r[8*j +: 8];
         end
      end
   end

   // Register storage; a pulse register falls back to the reset value one
   // cycle after the strobe, i.e. it holds the written value exactly once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_r   <= RESET_VALUE;
         strobe_r <= 1'b0;
      end else begin
         strobe_r <= wr_en;
         if (wr_en) begin
            data_r <= merged_s;
         end else if (AUTOCLEAR && strobe_r) begin
            data_r <= RESET_VALUE;
         end else begin
            data_r <= data_r;
         end
      end
   end

   assign data_out  = data_r;
   assign wr_strobe = strobe_r;

endmodule

// File: rtl/opb_register_bank.sv
// -----------------------------------------------------------------------------
// opb_register_bank
// OPB slave exposing C_NUM_REGS 32-bit user registers. A hit is sampled in
// IDLE, acknowledged in the single ACK cycle and the slave then waits in HOLD
// until OPB_select drops. Writes land at the end of ACK.
// Ports:
//   OPB_Clk, OPB_Rst : clock, asynchronous active-high reset
//   opb              : OPB slave bus bundle
//   user_data_out    : register i on bits [32i+31:32i]
//   user_wr_strobe   : one-cycle pulse per completed write to register i
// -----------------------------------------------------------------------------
module opb_register_bank
   import opb_register_bank_pkg::*;
#(
   parameter logic [31:0]           C_BASEADDR       = 32'h0100_0200,
   parameter logic [31:0]           C_HIGHADDR       = 32'h0100_02FF,
   parameter int                    C_NUM_REGS       = 4,
   parameter logic [31:0]           C_RESET_VALUE    = 32'h0000_0000,
   parameter logic [C_NUM_REGS-1:0] C_AUTOCLEAR_MASK = {C_NUM_REGS{1'b0}}
) (
   input  logic                         OPB_Clk,
   input  logic                         OPB_Rst,
   opb_register_bank_if.slave           opb,
   output logic [32*C_NUM_REGS-1:0]     user_data_out,
   output logic [C_NUM_REGS-1:0]        user_wr_strobe
);

   opb_state_e          state_r;
   logic [WORD_W-1:0]   index_r;
   logic [WORD_W-1:0]   wr_data_r;
   logic [BYTE_LANES-1:0] wr_be_r;
   logic                rnw_r;
   logic                xfer_ack_r;
   logic [WORD_W-1:0]   rd_data_r;

   logic                hit_s;
   logic [WORD_W-1:0]   hit_index_s;
   logic [WORD_W-1:0]   rd_mux_s;
   logic [C_NUM_REGS-1:0] wr_en_s;
   logic [WORD_W-1:0]   slot_data_s [C_NUM_REGS];
   logic                unused_seq_addr_s;

   // Sequential-address hint carries no meaning for single-beat registers.
   assign unused_seq_addr_s = opb.OPB_seqAddr;

   // Address decode of the live bus.
   always_comb begin
      hit_s       = opb.OPB_select &&
                    (opb.OPB_ABus >= C_BASEADDR) &&
                    (opb.OPB_ABus <= C_HIGHADDR);
      hit_index_s = addr_to_index(opb.OPB_ABus, C_BASEADDR);
   end

   // Readback mux; indexes past the implemented registers read as zero.
   // Register contents cannot change between the hit and ACK (writes only
   // happen in ACK and a pulse register has cleared before the next hit), so
   // the read word is captured at the hit and presented from a flop in ACK.
   always_comb begin
      rd_mux_s = 32'h0000_0000;
      for (int i = 0; i < C_NUM_REGS; i++) begin
         if (hit_index_s == 32'(i)) begin
            rd_mux_s = slot_data_s[i];
         end else begin
            rd_mux_s = rd_mux_s;
         end
      end
   end

   // Write request to the addressed slot during ACK; out-of-range is dropped.
   always_comb begin
      wr_en_s = {C_NUM_REGS{1'b0}};
      for (int i = 0; i < C_NUM_REGS; i++) begin
         if ((state_r == ST_ACK) && !rnw_r && (index_r == 32'(i))) begin
            wr_en_s[i] = 1'b1;
         end else begin
            wr_en_s[i] = 1'b0;
         end
      end
   end

   // Transfer FSM with registered acknowledge and read data. Reset during
   // ACK forces IDLE before the write edge, which cancels the pending write.
   always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
      if (OPB_Rst) begin
         state_r    <= ST_IDLE;
         index_r    <= 32'h0000_0000;
         wr_data_r  <= 32'h0000_0000;
         wr_be_r    <= 4'b0000;
         rnw_r      <= 1'b1;
         xfer_ack_r <= 1'b0;
         rd_data_r  <= 32'h0000_0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (hit_s) begin
                  state_r    <= ST_ACK;
                  xfer_ack_r <= 1'b1;
                  index_r    <= hit_index_s;
                  // Big-endian bus maps straight onto the user word:
                  // OPB_DBus[0] is user bit 31, OPB_BE[0] is wr_be_r[3].
                  wr_data_r  <= opb.OPB_DBus;
                  wr_be_r    <= opb.OPB_BE;
                  rnw_r      <= opb.OPB_RNW;
                  rd_data_r  <= opb.OPB_RNW ? rd_mux_s : 32'h0000_0000;
               end else begin
                  state_r    <= ST_IDLE;
                  xfer_ack_r <= 1'b0;
                  rd_data_r  <= 32'h0000_0000;
               end
            end
            ST_ACK: begin
               state_r    <= ST_HOLD;
               xfer_ack_r <= 1'b0;
               rd_data_r  <= 32'h0000_0000;
            end
            ST_HOLD: begin
               state_r    <= opb.OPB_select ? ST_HOLD : ST_IDLE;
               xfer_ack_r <= 1'b0;
               rd_data_r  <= 32'h0000_0000;
            end
            default: begin
               state_r    <= ST_IDLE;
               xfer_ack_r <= 1'b0;
               rd_data_r  <= 32'h0000_0000;
            end
         endcase
      end
   end

   assign opb.Sl_DBus    = rd_data_r;
   assign opb.Sl_xferAck = xfer_ack_r;
   assign opb.Sl_errAck  = 1'b0;
   assign opb.Sl_retry   = 1'b0;
   assign opb.Sl_toutSup = 1'b0;

   for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_slot
      opb_reg_slot #(
         .RESET_VALUE (C_RESET_VALUE),
         .AUTOCLEAR   (C_AUTOCLEAR_MASK[i])
      ) u_slot (
         .clk       (OPB_Clk),
         .rst       (OPB_Rst),
         .wr_en     (wr_en_s[i]),
         .wr_data   (wr_data_r),
         .wr_be     (wr_be_r),
         .data_out  (slot_data_s[i]),
         .wr_strobe (user_wr_strobe[i])
      );
      assign user_data_out[32*i +: 32] = slot_data_s[i];
   end

endmodule

// File: tb/tb_opb_register_bank.sv
// -----------------------------------------------------------------------------
// tb_opb_register_bank
// Directed bench for opb_register_bank. Two instances see identical bus
// traffic: dut_a with default parameters, dut_b with register 0 as a pulse
// register. Inputs change on the falling edge and outputs are observed there.
// -----------------------------------------------------------------------------
module tb_opb_register_bank;

   localparam logic [31:0] BASE = 32'h0100_0200;
   localparam logic [31:0] HIGH = 32'h0100_02FF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   opb_register_bank_if bus_a ();
   opb_register_bank_if bus_b ();

   assign bus_b.OPB_ABus    = bus_a.OPB_ABus;
   assign bus_b.OPB_BE      = bus_a.OPB_BE;
   assign bus_b.OPB_DBus    = bus_a.OPB_DBus;
   assign bus_b.OPB_RNW     = bus_a.OPB_RNW;
   assign bus_b.OPB_select  = bus_a.OPB_select;
   assign bus_b.OPB_seqAddr = bus_a.OPB_seqAddr;

   logic [127:0] udo_a, udo_b;
   logic [3:0]   str_a, str_b;

   opb_register_bank #(
      .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_NUM_REGS(4),
      .C_RESET_VALUE(32'h0000_0000), .C_AUTOCLEAR_MASK(4'b0000)
   ) dut_a (
      .OPB_Clk(clk), .OPB_Rst(rst), .opb(bus_a.slave),
      .user_data_out(udo_a), .user_wr_strobe(str_a)
   );

   opb_register_bank #(
      .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_NUM_REGS(4),
      .C_RESET_VALUE(32'h0000_0000), .C_AUTOCLEAR_MASK(4'b0001)
   ) dut_b (
      .OPB_Clk(clk), .OPB_Rst(rst), .opb(bus_b.slave),
      .user_data_out(udo_b), .user_wr_strobe(str_b)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   logic [31:0] model_a [4];

   task automatic drive(input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input logic rnw);
      bus_a.OPB_ABus   = addr;
      bus_a.OPB_DBus   = data;
      bus_a.OPB_BE     = be;
      bus_a.OPB_RNW    = rnw;
      bus_a.OPB_select = 1'b1;
   endtask

   task automatic release_bus();
      bus_a.OPB_select = 1'b0;
      bus_a.OPB_ABus   = 32'h0000_0000;
      bus_a.OPB_DBus   = 32'h0000_0000;
      bus_a.OPB_BE     = 4'b0000;
      bus_a.OPB_RNW    = 1'b0;
   endtask

   // Full write transfer (ACK, HOLD, back to IDLE) without observation.
   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] be);
      drive(addr, data, be, 1'b0);
      @(negedge clk);
      @(negedge clk);
      release_bus();
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      tests_run++;
      if (bus_a.Sl_xferAck !== 1'b0) begin tests_failed++; $display("FAIL reset_ack: got %b expected 0", bus_a.Sl_xferAck); end
      tests_run++;
      if (bus_a.Sl_DBus !== 32'h0) begin tests_failed++; $display("FAIL reset_dbus: got %h expected 0", bus_a.Sl_DBus); end
      tests_run++;
      if (udo_a !== 128'h0 || udo_b !== 128'h0) begin tests_failed++; $display("FAIL reset_regs: got %h / %h expected 0", udo_a, udo_b); end
      tests_run++;
      if (str_a !== 4'b0000) begin tests_failed++; $display("FAIL reset_strobe: got %b expected 0000", str_a); end
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({bus_a.Sl_errAck, bus_a.Sl_retry, bus_a.Sl_toutSup} !== 3'b000) begin
         tests_failed++; $display("FAIL const_outputs: got %b expected 000", {bus_a.Sl_errAck, bus_a.Sl_retry, bus_a.Sl_toutSup});
      end
   endtask

   task automatic test_write_full();
      drive(BASE + 32'h4, 32'hDEAD_BEEF, 4'b1111, 1'b0);
      @(negedge clk);
      tests_run++;
      if (bus_a.Sl_xferAck !== 1'b1) begin tests_failed++; $display("FAIL wr_ack: got %b expected 1", bus_a.Sl_xferAck); end
      tests_run++;
      if (str_a !== 4'b0000 || bus_a.Sl_DBus !== 32'h0) begin tests_failed++; $display("FAIL wr_ack_cycle: strobe %b dbus %h expected 0000/0", str_a, bus_a.Sl_DBus); end
      // Disturb the bus during ACK/HOLD; the captured transfer must win.
      bus_a.OPB_DBus = 32'h0000_0000;
      bus_a.OPB_BE   = 4'b0000;
      bus_a.OPB_ABus = BASE + 32'h8;
      bus_a.OPB_RNW  = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus_a.Sl_xferAck !== 1'b0) begin tests_failed++; $display("FAIL wr_ack_once: got %b expected 0", bus_a.Sl_xferAck); end
      tests_run++;
      if (udo_a[63:32] !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL wr_data: got %h expected deadbeef", udo_a[63:32]); end
      tests_run++;
      if (str_a !== 4'b0010) begin tests_failed++; $display("FAIL wr_strobe: got %b expected 0010", str_a); end
      release_bus();
      @(negedge clk);
      model_a[1] = 32'hDEAD_BEEF;
      tests_run++;
      if (str_a !== 4'b0000) begin tests_failed++; $display("FAIL wr_strobe_width: got %b expected 0000", str_a); end
      tests_run++;
      if (udo_a !== {model_a[3], model_a[2], model_a[1], model_a[0]}) begin tests_failed++; $display("FAIL wr_regs: got %h expected %h", udo_a, {model_a[3], model_a[2], model_a[1], model_a[0]}); end
   endtask

   task automatic test_byte_lanes();
      bus_write(BASE, 32'h1122_3344, 4'b1111);
      drive(BASE, 32'hAABB_CCDD, 4'b0101, 1'b0);
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (udo_a[31:0] !== 32'h11BB_33DD) begin tests_failed++; $display("FAIL be_merge: got %h expected 11bb33dd", udo_a[31:0]); end
      tests_run++;
      if (str_a !== 4'b0001) begin tests_failed++; $display("FAIL be_strobe: got %b expected 0001", str_a); end
      release_bus();
      @(negedge clk);
      model_a[0] = 32'h11BB_33DD;
      drive(BASE, 32'hFFFF_FFFF, 4'b1111, 1'b1);
      @(negedge clk);
      tests_run++;
      if (bus_a.Sl_xferAck !== 1'b1 || bus_a.Sl_DBus !== 32'h11BB_33DD) begin tests_failed++; $display("FAIL be_readback: ack %b dbus %h expected 1/11bb33dd", bus_a.Sl_xferAck, bus_a.Sl_DBus); end
      @(negedge clk);
      tests_run++;
      if (bus_a.Sl_DBus !== 32'h0) begin tests_failed++; $display("FAIL rd_dbus_hold: got %h expected 0", bus_a.Sl_DBus); end
      release_bus();
      @(negedge clk);
      // Zero byte enables still count as a completed write.
      drive(BASE + 32'hC, 32'hFFFF_FFFF, 4'b0000, 1'b0);
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (str_a !== 4'b1000 || udo_a[127:96] !== 32'h0) begin tests_failed++; $display("FAIL be_zero: strobe %b reg3 %h expected 1000/0", str_a, udo_a[127:96]); end
      release_bus();
      @(negedge clk);
   endtask

   task automatic test_autoclear();
      drive(BASE, 32'h0000_0001, 4'b1111, 1'b0);
      @(negedge clk);
      tests_run++;
      if (udo_b[31:0] !== 32'h0) begin tests_failed++; $display("FAIL pulse_early: got %h expected 0", udo_b[31:0]); end
      @(negedge clk);
      tests_run++;
      if (udo_b[31:0] !== 32'h1 || str_b !== 4'b0001) begin tests_failed++; $display("FAIL pulse_high: reg0 %h strobe %b expected 1/0001", udo_b[31:0], str_b); end
      release_bus();
      @(negedge clk);
      tests_run++;
      if (udo_b[31:0] !== 32'h0 || str_b !== 4'b0000) begin tests_failed++; $display("FAIL pulse_clear: reg0 %h strobe %b expected 0/0000", udo_b[31:0], str_b); end
      tests_run++;
      if (udo_a[31:0] !== 32'h1) begin tests_failed++; $display("FAIL plain_hold: got %h expected 1", udo_a[31:0]); end
      model_a[0] = 32'h0000_0001;
      drive(BASE, 32'h0, 4'b1111, 1'b1);
      @(negedge clk);
      tests_run++;
      if (bus_b.Sl_xferAck !== 1'b1 || bus_b.Sl_DBus !== 32'h0 || bus_a.Sl_DBus !== 32'h1) begin
         tests_failed++; $display("FAIL pulse_read: ack_b %b dbus_b %h dbus_a %h expected 1/0/1", bus_b.Sl_xferAck, bus_b.Sl_DBus, bus_a.Sl_DBus);
      end
      @(negedge clk);
      release_bus();
      @(negedge clk);
   endtask

   task automatic test_out_of_range();
      logic [31:0] miss_addr [2];
      int ack_cnt;
      int dbus_bad;
      drive(BASE + 32'h40, 32'h0, 4'b1111, 1'b1);
      @(negedge clk);
      tests_run++;
      if (bus_a.Sl_xferAck !== 1'b1 || bus_a.Sl_DBus !== 32'h0) begin tests_failed++; $display("FAIL oor_read: ack %b dbus %h expected 1/0", bus_a.Sl_xferAck, bus_a.Sl_DBus); end
      @(negedge clk);
      release_bus();
      @(negedge clk);
      drive(BASE + 32'h40, 32'hFFFF_FFFF, 4'b1111, 1'b0);
      @(negedge clk);
      tests_run++;
      if (bus_a.Sl_xferAck !== 1'b1) begin tests_failed++; $display("FAIL oor_write_ack: got %b expected 1", bus_a.Sl_xferAck); end
      @(negedge clk);
      tests_run++;
      if (str_a !== 4'b0000 || udo_a !== {model_a[3], model_a[2], model_a[1], model_a[0]}) begin
         tests_failed++; $display("FAIL oor_write_discard: strobe %b regs %h expected 0000/%h", str_a, udo_a, {model_a[3], model_a[2], model_a[1], model_a[0]});
      end
      release_bus();
      @(negedge clk);
      drive(HIGH, 32'h0, 4'b1111, 1'b1);
      @(negedge clk);
      tests_run++;
      if (bus_a.Sl_xferAck !== 1'b1 || bus_a.Sl_DBus !== 32'h0) begin tests_failed++; $display("FAIL high_edge: ack %b dbus %h expected 1/0", bus_a.Sl_xferAck, bus_a.Sl_DBus); end
      @(negedge clk);
      release_bus();
      @(negedge clk);
      miss_addr[0] = HIGH + 32'h4;
      miss_addr[1] = BASE - 32'h4;
      for (int k = 0; k < 2; k++) begin
         ack_cnt  = 0;
         dbus_bad = 0;
         drive(miss_addr[k], 32'hFFFF_FFFF, 4'b1111, 1'b0);
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus_a.Sl_xferAck === 1'b1) ack_cnt++;
            if (bus_a.Sl_DBus !== 32'h0) dbus_bad++;
         end
         tests_run++;
         if (ack_cnt !== 0 || dbus_bad !== 0 || str_a !== 4'b0000) begin
            tests_failed++; $display("FAIL miss_%0d: acks %0d dbus_nonzero %0d strobe %b expected 0/0/0000", k, ack_cnt, dbus_bad, str_a);
         end
         release_bus();
         @(negedge clk);
      end
   endtask

   task automatic test_reset_in_ack();
      drive(BASE + 32'h4, 32'h1234_5678, 4'b1111, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests_run++;
      if (bus_a.Sl_xferAck !== 1'b0 || bus_a.Sl_DBus !== 32'h0) begin tests_failed++; $display("FAIL rst_ack: ack %b dbus %h expected 0/0", bus_a.Sl_xferAck, bus_a.Sl_DBus); end
      tests_run++;
      if (udo_a !== 128'h0 || str_a !== 4'b0000) begin tests_failed++; $display("FAIL rst_regs: regs %h strobe %b expected 0/0000", udo_a, str_a); end
      @(negedge clk);
      tests_run++;
      if (udo_a !== 128'h0 || str_a !== 4'b0000) begin tests_failed++; $display("FAIL rst_no_write: regs %h strobe %b expected 0/0000", udo_a, str_a); end
      rst = 1'b0;
      for (int r = 0; r < 4; r++) model_a[r] = 32'h0;
      @(negedge clk);
      tests_run++;
      if (bus_a.Sl_xferAck !== 1'b1) begin tests_failed++; $display("FAIL rst_rehit: got %b expected 1", bus_a.Sl_xferAck); end
      @(negedge clk);
      tests_run++;
      if (udo_a[63:32] !== 32'h1234_5678 || str_a !== 4'b0010) begin tests_failed++; $display("FAIL rst_rehit_write: reg1 %h strobe %b expected 12345678/0010", udo_a[63:32], str_a); end
      release_bus();
      @(negedge clk);
      model_a[1] = 32'h1234_5678;
   endtask

   task automatic test_long_select();
      int ack_cnt;
      int first_ack;
      ack_cnt   = 0;
      first_ack = -1;
      drive(BASE + 32'h4, 32'h0, 4'b1111, 1'b1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus_a.Sl_xferAck === 1'b1) begin
            ack_cnt++;
            if (first_ack < 0) first_ack = c;
         end
      end
      tests_run++;
      if (ack_cnt !== 1 || first_ack !== 0) begin tests_failed++; $display("FAIL long_select: acks %0d first %0d expected 1/0", ack_cnt, first_ack); end
      release_bus();
      @(negedge clk);
      drive(BASE + 32'h4, 32'h0, 4'b1111, 1'b1);
      @(negedge clk);
      tests_run++;
      if (bus_a.Sl_xferAck !== 1'b1 || bus_a.Sl_DBus !== 32'h1234_5678) begin tests_failed++; $display("FAIL reselect: ack %b dbus %h expected 1/12345678", bus_a.Sl_xferAck, bus_a.Sl_DBus); end
      @(negedge clk);
      release_bus();
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [31:0] b2b_off  [3];
      logic [31:0] b2b_data [3];
      b2b_off[0] = 32'h8; b2b_data[0] = 32'hCAFE_F00D;
      b2b_off[1] = 32'hC; b2b_data[1] = 32'h0F0F_A5A5;
      b2b_off[2] = 32'h0; b2b_data[2] = 32'h8000_0001;
      for (int k = 0; k < 3; k++) begin
         bus_write(BASE + b2b_off[k], b2b_data[k], 4'b1111);
         model_a[b2b_off[k][3:2]] = b2b_data[k];
         drive(BASE + b2b_off[k], 32'h0, 4'b0000, 1'b1);
         @(negedge clk);
         tests_run++;
         if (bus_a.Sl_xferAck !== 1'b1 || bus_a.Sl_DBus !== b2b_data[k]) begin
            tests_failed++; $display("FAIL b2b_%0d: ack %b dbus %h expected 1/%h", k, bus_a.Sl_xferAck, bus_a.Sl_DBus, b2b_data[k]);
         end
         @(negedge clk);
         release_bus();
         @(negedge clk);
      end
      tests_run++;
      if (udo_a !== {model_a[3], model_a[2], model_a[1], model_a[0]}) begin tests_failed++; $display("FAIL b2b_regs: got %h expected %h", udo_a, {model_a[3], model_a[2], model_a[1], model_a[0]}); end
      tests_run++;
      if (udo_b[127:32] !== {model_a[3], model_a[2], model_a[1]} || udo_b[31:0] !== 32'h0) begin
         tests_failed++; $display("FAIL b2b_regs_b: got %h expected %h", udo_b, {model_a[3], model_a[2], model_a[1], 32'h0});
      end
   endtask

   initial begin
      for (int r = 0; r < 4; r++) model_a[r] = 32'h0;
      bus_a.OPB_seqAddr = 1'b0;
      release_bus();
      test_reset();
      test_write_full();
      test_byte_lanes();
      test_autoclear();
      test_out_of_range();
      test_reset_in_ack();
      test_long_select();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
